seq_gen: RTL

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/seq_gen.sv
// Serial pattern generator: sends a latched bit pattern MSB-first, repeated with optional idle gaps.
// Latency 1 cycle from accept to first bit; in_ready only in IDLE, descriptor inputs ignored otherwise.
module seq_gen #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_LEN-1:0] in_pattern,
    input  logic [4:0]         in_len,
    input  logic [CNT_W-1:0]   in_reps,
    input  logic [CNT_W-1:0]   in_gap,
    input  logic               abort,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state, state_n;

    // pat_q holds the pattern left-aligned so the first bit is always the MSB;
    // sh_q is the working copy shifted once per sent bit.
    logic [MAX_LEN-1:0] pat_q, pat_n;
    logic [MAX_LEN-1:0] sh_q, sh_n;
    logic [4:0]         len_q, len_n;
    logic [CNT_W-1:0]   gap_q, gap_n;
    logic [4:0]         bit_q, bit_n;
    logic [CNT_W-1:0]   rep_q, rep_n;
    logic [CNT_W-1:0]   gcnt_q, gcnt_n;
    logic               x_n, xv_n, done_n, busy_n;

    logic [4:0]         len_eff;
    logic [4:0]         shamt;
    logic [MAX_LEN-1:0] aligned;

    always_comb begin
        len_eff = ((in_len == 5'd0) || (in_len > MAX_LEN_W)) ? MAX_LEN_W : in_len;
        shamt   = MAX_LEN_W - len_eff;
        aligned = in_pattern << shamt;
    end

    assign in_ready = (state == IDLE);

    always_comb begin
        state_n = state;
        pat_n   = pat_q;
        sh_n    = sh_q;
        len_n   = len_q;
        gap_n   = gap_q;
        bit_n   = bit_q;
        rep_n   = rep_q;
        gcnt_n  = gcnt_q;
        x_n     = 1'b0;
        xv_n    = 1'b0;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n = SEND;
                    pat_n   = aligned;
                    sh_n    = aligned << 1;
                    len_n   = len_eff;
                    gap_n   = in_gap;
                    rep_n   = in_reps;
                    bit_n   = len_eff - 5'd1;
                    x_n     = aligned[MAX_LEN-1];
                    xv_n    = 1'b1;
                end
            end
            SEND: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (bit_q != 5'd0) begin
                    bit_n = bit_q - 5'd1;
                    x_n   = sh_q[MAX_LEN-1];
                    xv_n  = 1'b1;
                    sh_n  = sh_q << 1;
                end else if (rep_q != '0) begin
                    rep_n = rep_q - CNT_W'(1);
                    if (gap_q != '0) begin
                        state_n = GAP;
                        gcnt_n  = gap_q;
                    end else begin
                        bit_n = len_q - 5'd1;
                        x_n   = pat_q[MAX_LEN-1];
                        xv_n  = 1'b1;
                        sh_n  = pat_q << 1;
                    end
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (gcnt_q == CNT_W'(1)) begin
                    state_n = SEND;
                    bit_n   = len_q - 5'd1;
                    x_n     = pat_q[MAX_LEN-1];
                    xv_n    = 1'b1;
                    sh_n    = pat_q << 1;
                end else begin
                    gcnt_n = gcnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            gcnt_q  <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            pat_q   <= pat_n;
            sh_q    <= sh_n;
            len_q   <= len_n;
            gap_q   <= gap_n;
            bit_q   <= bit_n;
            rep_q   <= rep_n;
            gcnt_q  <= gcnt_n;
            x       <= x_n;
            x_valid <= xv_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule
